// File: rtl/aes_selftest_ctrl_if.sv
// Cipher / inverse-cipher core bus between the self-test controller and the two AES cores.
// The controller side is master; the core models/cores are slave.
interface aes_selftest_ctrl_if;
  logic         enc_start;
  logic [1:0]   enc_mode;
  logic [127:0] enc_din;
  logic         enc_done;
  logic [127:0] enc_dout;
  logic         dec_start;
  logic [127:0] dec_din;
  logic         dec_done;
  logic [127:0] dec_dout;

  modport master (
    output enc_start, enc_mode, enc_din, dec_start, dec_din,
    input  enc_done, enc_dout, dec_done, dec_dout
  );

  modport slave (
    input  enc_start, enc_mode, enc_din, dec_start, dec_din,
    output enc_done, enc_dout, dec_done, dec_dout
  );
endinterface

// File: rtl/aes_selftest_ctrl.sv
// AES self-test sequencer: encrypt, decrypt, compare, optionally chain ciphertext into the next round-trip.
// One round-trip is 6 cycles start-to-done with single-cycle cores; each core wait is bounded by TIMEOUT_CYC.
module aes_selftest_ctrl #(
  parameter int NUM_ITER    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          key_mode,
  input  logic [127:0]        plaintext,
  aes_selftest_ctrl_if.master core,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [1:0]          err_code,
  output logic [7:0]          result_byte,
  output logic [7:0]          iter_cnt
);

  typedef enum logic [2:0] {
    IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, FINISH
  } state_t;

  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT_CYC - 1);
  localparam logic [7:0] ITER_END = 8'(NUM_ITER);

  state_t       state, state_d;
  logic [1:0]   mode;
  logic [127:0] cur_blk, ct_reg, pt_reg;
  logic [9:0]   wait_cnt;
  logic [1:0]   err_d;
  logic         timeout, match, last_iter;

  // wait_cnt is 0 in the first wait cycle, so this flags the TIMEOUT_CYC-th wait cycle
  assign timeout   = (wait_cnt == TO_LAST);
  assign match     = (pt_reg == cur_blk);
  assign last_iter = ((iter_cnt + 8'd1) == ITER_END);

  always_comb begin
    state_d = state;
    err_d   = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          if (key_mode == 2'b11) begin
            state_d = FINISH;
            err_d   = 2'b11;
          end else begin
            state_d = ENC_REQ;
            err_d   = 2'b00;
          end
        end
      end
      ENC_REQ:  state_d = ENC_WAIT;
      ENC_WAIT: begin
        if (core.enc_done) begin
          state_d = DEC_REQ;
        end else if (timeout) begin
          state_d = FINISH;
          err_d   = 2'b10;
        end
      end
      DEC_REQ:  state_d = DEC_WAIT;
      DEC_WAIT: begin
        if (core.dec_done) begin
          state_d = CHECK;
        end else if (timeout) begin
          state_d = FINISH;
          err_d   = 2'b10;
        end
      end
      CHECK: begin
        if (!match) begin
          state_d = FINISH;
          err_d   = 2'b01;
        end else if (last_iter) begin
          state_d = FINISH;
        end else begin
          state_d = ENC_REQ;
        end
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= 2'b00;
      cur_blk     <= '0;
      ct_reg      <= '0;
      pt_reg      <= '0;
      wait_cnt    <= '0;
      err_code    <= 2'b00;
      pass        <= 1'b0;
      fail        <= 1'b0;
      result_byte <= 8'h00;
      iter_cnt    <= 8'h00;
    end else begin
      state    <= state_d;
      err_code <= err_d;

      if (state == IDLE && start) begin
        mode     <= key_mode;
        cur_blk  <= plaintext;
        pass     <= 1'b0;
        fail     <= 1'b0;
        iter_cnt <= 8'h00;
      end

      // verdict is registered on the way into FINISH so it is visible alongside done
      if (state_d == FINISH && state != FINISH) begin
        pass <= (err_d == 2'b00);
        fail <= (err_d != 2'b00);
      end

      if (state == ENC_REQ || state == DEC_REQ)
        wait_cnt <= '0;
      else if (state == ENC_WAIT || state == DEC_WAIT)
        wait_cnt <= wait_cnt + 10'd1;

      if (state == ENC_WAIT && core.enc_done) begin
        ct_reg      <= core.enc_dout;
        result_byte <= core.enc_dout[7:0];
      end

      if (state == DEC_WAIT && core.dec_done)
        pt_reg <= core.dec_dout;

      if (state == CHECK && match) begin
        iter_cnt <= iter_cnt + 8'd1;
        if (!last_iter)
          cur_blk <= ct_reg;
      end
    end
  end

  assign busy           = (state != IDLE);
  assign done           = (state == FINISH);
  assign core.enc_start = (state == ENC_REQ);
  assign core.dec_start = (state == DEC_REQ);
  assign core.enc_mode  = mode;
  assign core.enc_din   = cur_blk;
  assign core.dec_din   = ct_reg;

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Directed bench: two controller instances (single round-trip and 3-iteration chain) driven by
// behavioural cipher cores whose latency, key and corruption are set per step.
module tb_aes_selftest_ctrl;
  localparam int TO = 20;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K3    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start1 = 1'b0, start3 = 1'b0;
  logic [1:0]   key_mode1 = 2'b00, key_mode3 = 2'b00;
  logic [127:0] plaintext1 = '0, plaintext3 = '0;
  logic         busy1, done1, pass1, fail1, busy3, done3, pass3, fail3;
  logic [1:0]   err1, err3;
  logic [7:0]   res1, res3, iter1, iter3;

  aes_selftest_ctrl_if c1 ();
  aes_selftest_ctrl_if c3 ();

  aes_selftest_ctrl #(.NUM_ITER(1), .TIMEOUT_CYC(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_mode(key_mode1), .plaintext(plaintext1),
    .core(c1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .err_code(err1),
    .result_byte(res1), .iter_cnt(iter1)
  );

  aes_selftest_ctrl #(.NUM_ITER(3), .TIMEOUT_CYC(TO)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .key_mode(key_mode3), .plaintext(plaintext3),
    .core(c3), .busy(busy3), .done(done3), .pass(pass3), .fail(fail3), .err_code(err3),
    .result_byte(res3), .iter_cnt(iter3)
  );

  function automatic logic [127:0] f_enc(input logic [127:0] x, input logic [127:0] k);
    return {x[119:0], x[127:120]} ^ k;
  endfunction

  function automatic logic [127:0] f_dec(input logic [127:0] y, input logic [127:0] k);
    logic [127:0] z;
    z = y ^ k;
    return {z[7:0], z[127:8]};
  endfunction

  // core model settings; latency 0 means the core never answers
  int           elat1 = 1, dlat1 = 1, ecd1 = 0, dcd1 = 0, nenc1 = 0;
  logic [127:0] key1 = '0;
  logic         corrupt1 = 1'b0;
  int           ecd3 = 0, dcd3 = 0, nenc3 = 0;
  logic [127:0] log3 [0:7];

  always @(negedge clk) begin
    c1.enc_done = 1'b0;
    c1.dec_done = 1'b0;
    if (ecd1 > 0) begin
      ecd1--;
      if (ecd1 == 0) begin
        c1.enc_done = 1'b1;
        c1.enc_dout = f_enc(c1.enc_din, key1);
      end
    end
    if (dcd1 > 0) begin
      dcd1--;
      if (dcd1 == 0) begin
        c1.dec_done = 1'b1;
        c1.dec_dout = f_dec(c1.dec_din, key1) ^ {127'd0, corrupt1};
      end
    end
    if (c1.enc_start === 1'b1) begin
      ecd1 = elat1;
      nenc1++;
    end
    if (c1.dec_start === 1'b1) dcd1 = dlat1;
  end

  always @(negedge clk) begin
    c3.enc_done = 1'b0;
    c3.dec_done = 1'b0;
    if (ecd3 > 0) begin
      ecd3--;
      if (ecd3 == 0) begin
        c3.enc_done = 1'b1;
        c3.enc_dout = f_enc(c3.enc_din, K3);
      end
    end
    if (dcd3 > 0) begin
      dcd3--;
      if (dcd3 == 0) begin
        c3.dec_done = 1'b1;
        c3.dec_dout = f_dec(c3.dec_din, K3);
      end
    end
    if (c3.enc_start === 1'b1) begin
      ecd3 = 1;
      if (nenc3 < 8) log3[nenc3] = c3.enc_din;
      nenc3++;
    end
    if (c3.dec_start === 1'b1) dcd3 = 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // raises start for one cycle and returns the number of cycles until done (bounded)
  task automatic go(input bit sel, input logic [1:0] km, input logic [127:0] pt, output int cyc);
    if (sel) begin
      key_mode3 = km; plaintext3 = pt; start3 = 1'b1;
    end else begin
      key_mode1 = km; plaintext1 = pt; start1 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    cyc = 1;
    while (((sel ? done3 : done1) !== 1'b1) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    bit saw_done;
    logic [127:0] e1, e2, e3;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_pass_fail", {pass1, fail1}, 2'b00);
    chk("rst_err", err1, 2'b00);
    chk("rst_res_iter", {res1, iter1}, 16'h0000);
    chk("rst_starts", {c1.enc_start, c1.dec_start}, 2'b00);
    chk("rst_din", {c1.enc_din, c1.dec_din[7:0], c1.enc_mode}, '0);
    chk("rst_busy3", busy3, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // three chained round-trips
    e1 = f_enc(PT, K3);
    e2 = f_enc(e1, K3);
    e3 = f_enc(e2, K3);
    nenc3 = 0;
    go(1'b1, 2'b00, PT, cyc);
    chk("chain_cycles", cyc, 16);
    chk("chain_enc_starts", nenc3, 3);
    chk("chain_din0", log3[0], PT);
    chk("chain_din1", log3[1], e1);
    chk("chain_din2", log3[2], e2);
    chk("chain_result", res3, e3[7:0]);
    chk("chain_iter", iter3, 8'd3);
    chk("chain_pass", {pass3, fail3, err3}, 4'b1000);

    // AES-128 known answer
    key1 = f_enc(PT, 128'd0) ^ CT128;
    nenc1 = 0;
    go(1'b0, 2'b00, PT, cyc);
    chk("a128_cycles", cyc, 6);
    chk("a128_result", res1, 8'h5a);
    chk("a128_pass", {pass1, fail1, err1}, 4'b1000);
    chk("a128_iter", iter1, 8'd1);
    chk("a128_enc_starts", nenc1, 1);
    @(negedge clk);
    chk("a128_done_pulse", {done1, busy1}, 2'b00);
    chk("a128_pass_hold", pass1, 1'b1);

    // AES-192 / AES-256
    key1 = f_enc(PT, 128'd0) ^ CT192;
    go(1'b0, 2'b01, PT, cyc);
    chk("a192_mode", c1.enc_mode, 2'b01);
    chk("a192_result", res1, 8'h91);
    chk("a192_pass", {pass1, fail1, err1}, 4'b1000);
    @(negedge clk);
    key1 = f_enc(PT, 128'd0) ^ CT256;
    go(1'b0, 2'b10, PT, cyc);
    chk("a256_mode", c1.enc_mode, 2'b10);
    chk("a256_result", res1, 8'h89);
    chk("a256_pass", {pass1, fail1, err1}, 4'b1000);
    @(negedge clk);

    // inverse core returns pt^1
    corrupt1 = 1'b1;
    go(1'b0, 2'b00, PT, cyc);
    chk("mism_cycles", cyc, 6);
    chk("mism_flags", {pass1, fail1, err1}, 4'b0101);
    chk("mism_iter", iter1, 8'd0);
    corrupt1 = 1'b0;
    @(negedge clk);

    // enc_done withheld: done TO cycles after ENC_WAIT entry
    elat1 = 0;
    go(1'b0, 2'b00, PT, cyc);
    chk("tmo_cycles", cyc, TO + 2);
    chk("tmo_flags", {pass1, fail1, err1}, 4'b0110);
    @(negedge clk);

    // enc_done in the very cycle the timeout would fire
    elat1 = TO;
    go(1'b0, 2'b00, PT, cyc);
    chk("edge_cycles", cyc, TO + 5);
    chk("edge_flags", {pass1, fail1, err1}, 4'b1000);
    elat1 = 1;
    @(negedge clk);

    // reserved key mode
    nenc1 = 0;
    go(1'b0, 2'b11, PT, cyc);
    chk("bad_cycles", cyc, 1);
    chk("bad_flags", {pass1, fail1, err1}, 4'b0111);
    chk("bad_enc_starts", nenc1, 0);
    @(negedge clk);

    // start while busy is ignored
    key1 = f_enc(PT, 128'd0) ^ CT128;
    nenc1 = 0;
    key_mode1 = 2'b00; plaintext1 = PT; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    start1 = 1'b1; key_mode1 = 2'b11; plaintext1 = ~PT;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 3;
    while (done1 !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_cycles", cyc, 6);
    chk("busy_mode", c1.enc_mode, 2'b00);
    chk("busy_flags", {pass1, fail1, err1}, 4'b1000);
    chk("busy_enc_starts", nenc1, 1);
    @(negedge clk);

    // reset during DEC_WAIT, then a late dec_done
    dlat1 = 5;
    key_mode1 = 2'b01; plaintext1 = PT; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {busy1, done1, pass1, fail1, err1}, 6'b0);
    chk("mid_rst_regs", {res1, iter1, c1.enc_mode}, 18'b0);
    chk("mid_rst_din", {c1.enc_din, c1.dec_din[7:0]}, '0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1'b1;
    end
    chk("late_done_ignored", saw_done, 1'b0);
    chk("late_regs", {pass1, fail1, err1, res1, iter1}, 20'b0);
    chk("late_dec_din", c1.dec_din, 128'd0);
    dlat1 = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
